fila_circ: RTL and testbench

//  Parametrised circular-buffer FIFO; successor to the 8x8 shift-register queue.

---
 rtl/fila_pkg.sv | 15 +
 rtl/fila_circ_if.sv | 49 ++++
 rtl/fila_mem.sv | 25 ++
 rtl/fila_circ.sv | 109 ++++++++++
 tb/tb_fila_circ.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fila_pkg.sv
// Shared definitions for the circular-buffer FIFO (fila_circ).
// Default geometry and the pointer wrap helper used by the head/tail logic.
package fila_pkg;

  localparam int FILA_WIDTH_DEF = 8;
  localparam int FILA_DEPTH_DEF = 8;

  // Advance a ring pointer by one, wrapping DEPTH-1 -> 0 by explicit compare
  // so that non-power-of-two depths work.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fila_circ_if.sv
// Bus interface for fila_circ: request/data inputs and status outputs.
// Optional feature macro: FILA_CIRC_ERR_EN adds sticky overflow/underflow flags.
//
// Handshake: enqueue_in and dequeue_in are single-cycle requests sampled on
// every rising edge; there is no ready signal. The producer watches full_out
// and the consumer watches empty_out. A request that cannot be honoured is
// dropped. data_valid_out pulses for exactly one cycle when data_out was
// loaded at the preceding edge.
interface fila_circ_if
  import fila_pkg::*;
#(
  parameter int WIDTH = FILA_WIDTH_DEF,
  parameter int DEPTH = FILA_DEPTH_DEF
) ();

  localparam int LEN_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_in;
  logic             enqueue_in;
  logic             dequeue_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid_out;
  logic [LEN_W-1:0] len_out;
  logic             full_out;
  logic             empty_out;
`ifdef FILA_CIRC_ERR_EN
  logic             overflow_out;
  logic             underflow_out;
`endif

  // Producer/consumer side
  modport master (
    output data_in, enqueue_in, dequeue_in,
    input  data_out, data_valid_out, len_out, full_out, empty_out
`ifdef FILA_CIRC_ERR_EN
    , input overflow_out, underflow_out
`endif
  );

  // FIFO side
  modport slave (
    input  data_in, enqueue_in, dequeue_in,
    output data_out, data_valid_out, len_out, full_out, empty_out
`ifdef FILA_CIRC_ERR_EN
    , output overflow_out, underflow_out
`endif
  );

endinterface

// File: rtl/fila_mem.sv
// Storage array for fila_circ: one synchronous write port, one
// combinational read port. Contents are intentionally not reset.
module fila_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_10KHz,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on an accepted enqueue
  always_ff @(posedge clk_10KHz) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fila_circ.sv
// Circular-buffer FIFO with head/tail pointers and registered status.
// Optional feature macro: FILA_CIRC_ERR_EN adds sticky overflow_out and
// underflow_out flags; without it rejected requests are silently dropped.
module fila_circ
  import fila_pkg::*;
#(
  parameter int WIDTH = FILA_WIDTH_DEF,
  parameter int DEPTH = FILA_DEPTH_DEF
) (
  input  logic        clk_10KHz,
  input  logic        reset,
  fila_circ_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_next;
  logic             enq_ok;
  logic             deq_ok;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             full_q;
  logic             empty_q;

  fila_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_10KHz (clk_10KHz),
    .wr_en     (enq_ok),
    .wr_addr   (tail),
    .wr_data   (bus.data_in),
    .rd_addr   (head),
    .rd_data   (rd_data)
  );

  // Accept decisions from pre-edge flags; a dequeue frees a slot so a full
  // FIFO still takes an enqueue in the same cycle. An empty FIFO never
  // forwards the incoming word straight to data_out.
  always_comb begin
    deq_ok     = bus.dequeue_in & ~empty_q;
    enq_ok     = bus.enqueue_in & (~full_q | deq_ok);
    count_next = count;
    case ({enq_ok, deq_ok})
      2'b10:   count_next = count + LEN_W'(1);
      2'b01:   count_next = count - LEN_W'(1);
      default: count_next = count;
    endcase
  end

  // Pointers, occupancy and flags; flags track the post-update count
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (enq_ok) tail <= PTR_W'(ptr_next(32'(tail), $unsigned(DEPTH)));
      if (deq_ok) head <= PTR_W'(ptr_next(32'(head), $unsigned(DEPTH)));
      count   <= count_next;
      full_q  <= (count_next == LEN_W'(DEPTH));
      empty_q <= (count_next == '0);
    end
  end

  // Output word register and its one-cycle valid pulse
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= deq_ok;
      if (deq_ok) data_q <= rd_data;
    end
  end

`ifdef FILA_CIRC_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.enqueue_in & ~enq_ok)   overflow_q  <= 1'b1;
      if (bus.dequeue_in & empty_q)   underflow_q <= 1'b1;
    end
  end

  assign bus.overflow_out  = overflow_q;
  assign bus.underflow_out = underflow_q;
`endif

  assign bus.data_out       = data_q;
  assign bus.data_valid_out = valid_q;
  assign bus.len_out        = count;
  assign bus.full_out       = full_q;
  assign bus.empty_out      = empty_q;

endmodule

// File: tb/tb_fila_circ.sv
// Directed testbench for fila_circ (WIDTH=8, DEPTH=8).
// Compile with FILA_CIRC_ERR_EN defined to also check the sticky error flags.
module tb_fila_circ;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;
  logic [7:0] exp_q[$];
  logic [7:0] last_out;

  fila_circ_if #(.WIDTH(8), .DEPTH(8)) bus ();

  fila_circ #(.WIDTH(8), .DEPTH(8)) dut (
    .clk_10KHz (clk),
    .reset     (reset),
    .bus       (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input int len, input logic full, input logic empty);
    chk({tag, ".len"},   32'(bus.len_out),   32'(len));
    chk({tag, ".full"},  32'(bus.full_out),  32'(full));
    chk({tag, ".empty"}, 32'(bus.empty_out), 32'(empty));
  endtask

  // Driver: apply one cycle of requests, sample 1 time unit after the edge
  task automatic step(input logic en, input logic de, input logic [7:0] din);
    @(negedge clk);
    bus.enqueue_in = en;
    bus.dequeue_in = de;
    bus.data_in    = din;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] din);
    step(1'b1, 1'b0, din);
    exp_q.push_back(din);
  endtask

  // Dequeue and compare against the scoreboard head
  task automatic pop_chk(input string tag);
    logic [7:0] e;
    step(1'b0, 1'b1, 8'h00);
    if (exp_q.size() == 0) begin
      chk({tag, ".queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".data"},  32'(bus.data_out),       32'(e));
      chk({tag, ".valid"}, 32'(bus.data_valid_out), 32'd1);
      last_out = e;
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fails        = 0;
    last_out       = 8'h00;
    reset          = 1'b1;
    bus.enqueue_in = 1'b0;
    bus.dequeue_in = 1'b0;
    bus.data_in    = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_status("rst", 0, 1'b0, 1'b1);
    chk("rst.data",  32'(bus.data_out),       32'h0);
    chk("rst.valid", 32'(bus.data_valid_out), 32'h0);
`ifdef FILA_CIRC_ERR_EN
    chk("rst.ovf", 32'(bus.overflow_out),  32'h0);
    chk("rst.unf", 32'(bus.underflow_out), 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    chk_status("idle", 0, 1'b0, 1'b1);
    chk("idle.data", 32'(bus.data_out), 32'h0);

    // Fill with 0x11..0x18
    for (int i = 0; i < 8; i++) begin
      push(8'h11 + 8'(i));
      chk("fill.len", 32'(bus.len_out), 32'(i + 1));
    end
    chk_status("full", 8, 1'b1, 1'b0);

    // Ninth enqueue is dropped
    step(1'b1, 1'b0, 8'h99);
    chk_status("ovf", 8, 1'b1, 1'b0);
    chk("ovf.valid", 32'(bus.data_valid_out), 32'h0);
`ifdef FILA_CIRC_ERR_EN
    chk("ovf.flag", 32'(bus.overflow_out), 32'h1);
`endif

    // Drain in order
    for (int i = 0; i < 8; i++) begin
      pop_chk("drain");
      chk("drain.len", 32'(bus.len_out), 32'(7 - i));
    end
    chk_status("drained", 0, 1'b0, 1'b1);

    // Dequeue on empty is ignored, data_out holds
    step(1'b0, 1'b1, 8'h00);
    chk("unf.valid", 32'(bus.data_valid_out), 32'h0);
    chk("unf.data",  32'(bus.data_out),       32'h18);
    chk_status("unf", 0, 1'b0, 1'b1);
`ifdef FILA_CIRC_ERR_EN
    chk("unf.flag", 32'(bus.underflow_out), 32'h1);
`endif

    // Wrap: enqueue 5, dequeue 3, enqueue 6
    for (int i = 0; i < 5; i++) push(8'h21 + 8'(i));
    for (int i = 0; i < 3; i++) pop_chk("wrap_a");
    chk("wrap.len2", 32'(bus.len_out), 32'd2);
    for (int i = 0; i < 6; i++) push(8'h31 + 8'(i));
    chk_status("wrap_full", 8, 1'b1, 1'b0);

    // Full with simultaneous enqueue/dequeue: head 0x24 out, 0xAA queued
    step(1'b1, 1'b1, 8'hAA);
    chk("fboth.data",  32'(bus.data_out),       32'h24);
    chk("fboth.valid", 32'(bus.data_valid_out), 32'h1);
    chk_status("fboth", 8, 1'b1, 1'b0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    exp_q.push_back(8'hAA);

    // Drain across the wrap; 0xAA comes out last
    for (int i = 0; i < 8; i++) pop_chk("wrap_drain");
    chk("wrap_drain.last", 32'(last_out), 32'hAA);
    chk_status("wrap_empty", 0, 1'b0, 1'b1);

    // Empty with simultaneous enqueue/dequeue: no bypass
    step(1'b1, 1'b1, 8'h55);
    exp_q.push_back(8'h55);
    chk("eboth.valid", 32'(bus.data_valid_out), 32'h0);
    chk("eboth.data",  32'(bus.data_out),       32'hAA);
    chk_status("eboth", 1, 1'b0, 1'b0);

    // Reach five entries, then reset mid-stream away from any edge
    for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
    chk("pre_rst.len", 32'(bus.len_out), 32'd5);
    step(1'b0, 1'b0, 8'h00);
    #10;
    reset = 1'b1;
    #1;
    chk_status("mid_rst", 0, 1'b0, 1'b1);
    chk("mid_rst.data",  32'(bus.data_out),       32'h0);
    chk("mid_rst.valid", 32'(bus.data_valid_out), 32'h0);
`ifdef FILA_CIRC_ERR_EN
    chk("mid_rst.ovf", 32'(bus.overflow_out),  32'h0);
    chk("mid_rst.unf", 32'(bus.underflow_out), 32'h0);
`endif
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;

    // Old entries are gone; new traffic starts fresh
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst.valid", 32'(bus.data_valid_out), 32'h0);
    push(8'h77);
    chk_status("post_rst", 1, 1'b0, 1'b0);
    pop_chk("post_rst");
    chk_status("post_rst_end", 0, 1'b0, 1'b1);

    step(1'b0, 1'b0, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails + 1);
    $fatal(1, "timeout");
  end

endmodule
